// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and helpers for the serial TX write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package serial_tx_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Index width for a requester count; never returns less than 1 bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Round-robin picker: the first requester found when scanning from ptr
// upward with wrap-around modulo N.
module rr_pick
   import serial_tx_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  REQ,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx
);

   int   pos;
   logic found;

   always_comb begin
      idx   = ptr;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         for (int i = 0; i < N; i++) begin
            if (!found && (i == pos) && REQ[i]) begin
               idx   = IW'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the UART TX FIFO write port
// between N byte sources, with FULL throttling and an idle-grant timeout.
module serial_tx_arbiter
   import serial_tx_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic           CLK_WR,
   input  logic           RST,
   input  logic [N-1:0]   REQ,
   input  logic [N-1:0]   LAST,
   input  logic [8*N-1:0] DATA_IN,
   input  logic           FULL,
   output logic [N-1:0]   ACK,
   output logic [N-1:0]   GNT,
   output logic           WR_EN,
   output logic [7:0]     DATA,
   output logic           BUSY,
   output logic           TMO_ERR
);

   localparam int IW = clog2(N);

   state_t          state_q, state_d;
   logic [IW-1:0]   g_q, g_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            wr_en_q, wr_en_d;
   logic [7:0]      data_q, data_d;
   logic            tmo_err_q, tmo_err_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   next_ptr;
   logic [7:0]      sel_byte;
   logic            hs;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_rr_pick (
      .REQ (REQ),
      .ptr (ptr_q),
      .idx (pick_idx)
   );

   assign sel_byte = DATA_IN[{g_q, 3'b000} +: 8];
   assign next_ptr = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
   assign hs       = (state_q == XFER) && REQ[g_q] && !FULL;

   // gnt_q is one-hot on the owner while in XFER, so it doubles as the ACK mask.
   assign ACK     = hs ? gnt_q : '0;
   assign GNT     = gnt_q;
   assign WR_EN   = wr_en_q;
   assign DATA    = data_q;
   assign BUSY    = (state_q != IDLE);
   assign TMO_ERR = tmo_err_q;

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      wr_en_d   = 1'b0;
      data_d    = data_q;
      tmo_err_d = 1'b0;
      tcnt_d    = tcnt_q;

      case (state_q)
         IDLE: begin
            if (|REQ) begin
               g_d     = pick_idx;
               gnt_d   = N'(1) << pick_idx;
               tcnt_d  = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (hs) begin
               wr_en_d = 1'b1;
               data_d  = sel_byte;
               tcnt_d  = '0;
               if (LAST[g_q]) begin
                  gnt_d   = '0;
                  ptr_d   = next_ptr;
                  state_d = IDLE;
               end
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               // Owner stalled (silent or sink stuck full): revoke and move on.
               gnt_d     = '0;
               tmo_err_d = 1'b1;
               ptr_d     = next_ptr;
               tcnt_d    = '0;
               state_d   = IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK_WR) begin
      if (!RST) begin
         state_q   <= IDLE;
         g_q       <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         wr_en_q   <= 1'b0;
         data_q    <= 8'h00;
         tmo_err_q <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         wr_en_q   <= wr_en_d;
         data_q    <= data_d;
         tmo_err_q <= tmo_err_d;
         tcnt_q    <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: queue-driven sources, a
// packet-level reference model compared every cycle, and literal pins.
module tb_serial_tx_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 16;
   localparam int TW      = 5;

   logic           CLK_WR = 1'b0;
   logic           RST;
   logic [N-1:0]   REQ;
   logic [N-1:0]   LAST;
   logic [8*N-1:0] DATA_IN;
   logic           FULL;
   logic [N-1:0]   ACK;
   logic [N-1:0]   GNT;
   logic           WR_EN;
   logic [7:0]     DATA;
   logic           BUSY;
   logic           TMO_ERR;

   serial_tx_arbiter #(
      .N       (N),
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .CLK_WR  (CLK_WR),
      .RST     (RST),
      .REQ     (REQ),
      .LAST    (LAST),
      .DATA_IN (DATA_IN),
      .FULL    (FULL),
      .ACK     (ACK),
      .GNT     (GNT),
      .WR_EN   (WR_EN),
      .DATA    (DATA),
      .BUSY    (BUSY),
      .TMO_ERR (TMO_ERR)
   );

   always #5 CLK_WR = ~CLK_WR;

   // Source packet buffers: {last, byte}
   logic [8:0] sbuf [N][32];
   int         shead [N];
   int         stail [N];
   logic       full_v;
   logic       rst_v;

   // Reference model (registered outputs as of the latest edge)
   int         m_owner;
   int         m_ptr;
   int         m_idle;
   logic       m_wr;
   logic       m_tmo;
   logic [7:0] m_data;
   logic       started;

   int         cyc;
   int         n_checks;
   int         n_pass;

   // Observations of the DUT
   logic [7:0] wdat [$];
   int         wcyc [$];
   int         gidx [$];
   int         gcyc [$];
   int         aidx [$];
   int         acyc [$];
   int         tcyc [$];
   logic [N-1:0] prev_gnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [N-1:0] model_ack();
      logic [N-1:0] a;
      a = '0;
      if (m_owner >= 0 && REQ[m_owner] && !FULL) a[m_owner] = 1'b1;
      return a;
   endfunction

   task automatic push(input int s, input logic [7:0] b, input logic l);
      sbuf[s][stail[s]] = {l, b};
      stail[s]++;
   endtask

   task automatic clear_logs();
      wdat.delete(); wcyc.delete(); gidx.delete(); gcyc.delete();
      aidx.delete(); acyc.delete(); tcyc.delete();
   endtask

   // Idle sources present LAST=1 and junk data without REQ; must be ignored.
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (shead[i] < stail[i]) begin
            REQ[i]            = 1'b1;
            LAST[i]           = sbuf[i][shead[i]][8];
            DATA_IN[8*i +: 8] = sbuf[i][shead[i]][7:0];
         end else begin
            REQ[i]            = 1'b0;
            LAST[i]           = 1'b1;
            DATA_IN[8*i +: 8] = 8'hEE;
         end
      end
      FULL = full_v;
      RST  = rst_v;
   endtask

   task automatic compare();
      logic [N-1:0] eg;
      if (!started) return;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("ACK", 32'(ACK), 32'(model_ack()));
      chk("GNT", 32'(GNT), 32'(eg));
      chk("WR_EN", 32'(WR_EN), 32'(m_wr));
      if (m_wr) chk("DATA", 32'(DATA), 32'(m_data));
      chk("BUSY", 32'(BUSY), 32'(m_owner >= 0));
      chk("TMO_ERR", 32'(TMO_ERR), 32'(m_tmo));
      if (WR_EN === 1'b1) begin wdat.push_back(DATA); wcyc.push_back(cyc); end
      if (TMO_ERR === 1'b1) tcyc.push_back(cyc);
      for (int i = 0; i < N; i++) begin
         if (ACK[i] === 1'b1) begin aidx.push_back(i); acyc.push_back(cyc); end
         if (GNT[i] === 1'b1 && prev_gnt === '0) begin gidx.push_back(i); gcyc.push_back(cyc); end
      end
      prev_gnt = GNT;
   endtask

   task automatic update();
      logic [N-1:0] a;
      cyc++;
      a = model_ack();
      if (!RST) begin
         m_owner = -1; m_ptr = 0; m_idle = 0;
         m_wr = 1'b0; m_tmo = 1'b0; m_data = 8'h00;
         started = 1'b1;
      end else begin
         m_wr  = 1'b0;
         m_tmo = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
               if (m_owner < 0 && REQ[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            m_idle = 0;
         end else if (a != '0) begin
            m_wr   = 1'b1;
            m_data = DATA_IN[8*m_owner +: 8];
            m_idle = 0;
            if (LAST[m_owner]) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_tmo = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
         end
      end
      for (int i = 0; i < N; i++) if (a[i]) shead[i]++;
   endtask

   task automatic cycle();
      #1;
      drive();
      @(negedge CLK_WR);
      compare();
      @(posedge CLK_WR);
      update();
   endtask

   task automatic run_quiet(input int max_cyc);
      logic done;
      done = 1'b0;
      for (int n = 0; n < max_cyc && !done; n++) begin
         cycle();
         done = (m_owner < 0) && !m_wr && !m_tmo;
         for (int i = 0; i < N; i++) if (shead[i] != stail[i]) done = 1'b0;
      end
      chk("quiet_within_bound", 32'(done), 32'(1));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < N; i++) begin shead[i] = 0; stail[i] = 0; end
      full_v = 1'b0;
      rst_v  = 1'b0;
      repeat (n) cycle();
      rst_v  = 1'b1;
      clear_logs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0;
      started = 1'b0; m_owner = -1; m_ptr = 0; m_idle = 0;
      m_wr = 1'b0; m_tmo = 1'b0; m_data = 8'h00;
      prev_gnt = '0;
      for (int i = 0; i < N; i++) begin shead[i] = 0; stail[i] = 0; end
      full_v = 1'b0; rst_v = 1'b0;
      @(posedge CLK_WR);

      // Reset then idle
      do_reset(3);
      repeat (10) cycle();
      chk("idle_gnt", 32'(GNT), 32'(0));
      chk("idle_wr_en", 32'(WR_EN), 32'(0));
      chk("idle_data", 32'(DATA), 32'h00);
      chk("idle_busy", 32'(BUSY), 32'(0));

      // Single packet from source 1
      clear_logs();
      push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
      run_quiet(20);
      chk("single_ack_count", 32'(acyc.size()), 32'(3));
      chk("single_ack_src", 32'(aidx[0]), 32'(1));
      chk("single_ack_consec", 32'(acyc[2] - acyc[0]), 32'(2));
      chk("single_wr_count", 32'(wdat.size()), 32'(3));
      chk("single_d0", 32'(wdat[0]), 32'h41);
      chk("single_d1", 32'(wdat[1]), 32'h42);
      chk("single_d2", 32'(wdat[2]), 32'h43);
      chk("single_latency", 32'(wcyc[0] - acyc[0]), 32'(1));
      chk("single_wr_consec", 32'(wcyc[2] - wcyc[0]), 32'(2));
      // Pointer now at 2: simultaneous requests from 0 and 2 favour 2
      clear_logs();
      push(0, 8'h01, 1'b1); push(2, 8'h02, 1'b1);
      run_quiet(20);
      chk("ptr_after_src1_first", 32'(gidx[0]), 32'(2));
      chk("ptr_after_src1_second", 32'(gidx[1]), 32'(0));

      // Round-robin with all sources requesting
      do_reset(2);
      for (int s = 0; s < N; s++) begin
         push(s, 8'(s * 16 + 1), 1'b1);
         push(s, 8'(s * 16 + 2), 1'b1);
      end
      run_quiet(60);
      chk("rr_g0", 32'(gidx[0]), 32'(0));
      chk("rr_g1", 32'(gidx[1]), 32'(1));
      chk("rr_g2", 32'(gidx[2]), 32'(2));
      chk("rr_g3", 32'(gidx[3]), 32'(3));
      chk("rr_g4", 32'(gidx[4]), 32'(0));
      for (int k = 0; k < 4; k++) chk("rr_spacing", 32'(gcyc[k+1] - gcyc[k]), 32'(2));
      chk("rr_w4", 32'(wdat[4]), 32'h02);

      // Atomicity: source 3 waits for source 0's whole packet
      do_reset(2);
      push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
      cycle(); cycle();
      push(3, 8'h33, 1'b1);
      run_quiet(30);
      chk("atom_g1", 32'(gidx[1]), 32'(3));
      chk("atom_ack4_src", 32'(aidx[3]), 32'(0));
      chk("atom_ack5_src", 32'(aidx[4]), 32'(3));
      chk("atom_w3", 32'(wdat[3]), 32'h13);
      chk("atom_w4", 32'(wdat[4]), 32'h33);

      // Backpressure: FULL for 5 cycles after source 2's first byte
      do_reset(2);
      push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
      cycle(); cycle();
      full_v = 1'b1;
      repeat (5) cycle();
      full_v = 1'b0;
      run_quiet(30);
      chk("bp_wr_count", 32'(wdat.size()), 32'(3));
      chk("bp_d0", 32'(wdat[0]), 32'hA0);
      chk("bp_d1", 32'(wdat[1]), 32'hA1);
      chk("bp_d2", 32'(wdat[2]), 32'hA2);
      chk("bp_stall_gap", 32'(wcyc[1] - wcyc[0]), 32'(6));

      // Timeout: source 0 goes silent mid-packet, source 1 pending
      do_reset(2);
      push(0, 8'h50, 1'b0);
      push(1, 8'h61, 1'b1);
      run_quiet(60);
      chk("tmo_pulses", 32'(tcyc.size()), 32'(1));
      chk("tmo_delay", 32'(tcyc[0] - wcyc[0]), 32'(16));
      chk("tmo_next_grant", 32'(gidx[1]), 32'(1));
      chk("tmo_grant_gap", 32'(gcyc[1] - tcyc[0]), 32'(1));
      chk("tmo_w1", 32'(wdat[1]), 32'h61);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
